// File: rtl/heap_pkg.sv
// heap_pkg: shared widths, record type and serializer state encoding for the heap drain path
package heap_pkg;
  localparam int HEAP_DATA_W = 384;
  localparam int HEAP_WORD_W = 64;
  localparam int HEAP_BEATS = HEAP_DATA_W / HEAP_WORD_W;
  typedef logic [HEAP_DATA_W-1:0] heap_record_t;
  typedef enum logic {IDLE, SEND} ser_state_t;
endpackage

// File: rtl/heap_record_fifo.sv
// heap_record_fifo: circular DEPTH x DATA_W record buffer; push/pop in, dout at rd_ptr, registered level, full/empty out
module heap_record_fifo
  import heap_pkg::*;
#(
  parameter int DATA_W = HEAP_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    full = level == LW'(DEPTH);
    empty = level == '0;
    do_push = push && !full && !rst;
    do_pop = pop && !empty;
    dout = mem[rd_ptr];
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/heap_record_serializer.sv
// heap_record_serializer: buffers heap records (dIn/dInValid) and streams them as WORD_W beats (wordOut/wordValid/wordReady/wordFirst/wordLast); level, sticky overflow, saturating dropCount
module heap_record_serializer
  import heap_pkg::*;
#(
  parameter int DATA_W = HEAP_DATA_W,
  parameter int WORD_W = HEAP_WORD_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        dIn,
  input  logic                     dInValid,
  output logic [WORD_W-1:0]        wordOut,
  output logic                     wordValid,
  input  logic                     wordReady,
  output logic                     wordFirst,
  output logic                     wordLast,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         dropCount
);
  localparam int BEATS = DATA_W / WORD_W;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  ser_state_t state;
  logic [DATA_W-1:0] shift, dout;
  logic [BW-1:0] beat;
  logic empty, full, xfer, at_last, load, drop;
  always_comb begin
    xfer = state == SEND && wordReady;
    at_last = beat == LAST;
    load = !empty && (state == IDLE || (xfer && at_last));
    drop = dInValid && full;
    wordOut = shift[WORD_W-1:0];
    wordValid = state == SEND;
    wordFirst = wordValid && beat == '0;
    wordLast = wordValid && at_last;
  end
  heap_record_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(dInValid),
    .pop(load),
    .din(dIn),
    .dout(dout),
    .level(level),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      beat <= '0;
      overflow <= 1'b0;
      dropCount <= '0;
    end else begin
      if (load) begin
        state <= SEND;
        shift <= dout;
        beat <= '0;
      end else if (xfer && at_last) state <= IDLE;
      else if (xfer) begin
        shift <= shift >> WORD_W;
        beat <= beat + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (~&dropCount) dropCount <= dropCount + 1'b1;
      end
    end
endmodule

// File: tb/tb_heap_record_serializer.sv
// tb_heap_record_serializer: table-driven and scoreboard bench for heap_record_serializer
module tb_heap_record_serializer;
  import heap_pkg::*;
  typedef struct {logic [63:0] w; logic f; logic l;} beat_t;
  typedef struct {logic [63:0] base; logic [31:0] pat; int exp_xfers;} vec_t;
  logic clk = 0, rst = 1;
  heap_record_t dIn = '0;
  logic dInValid = 0, wordReady = 0, dInValid1 = 0, wordReady1 = 0;
  logic [63:0] wordOut, wordOut1;
  logic wordValid, wordFirst, wordLast, overflow;
  logic wordValid1, wordFirst1, wordLast1, overflow1;
  logic [2:0] level;
  logic [1:0] level1;
  logic [15:0] dropCount;
  logic [1:0] dropCount1;
  int n_cmp = 0, n_bad = 0, xfer_cnt = 0;
  beat_t q[$];
  beat_t prev, mon_e;
  logic prev_stall = 0;
  vec_t vecs[4];
  int el[6];

  always #5 clk = ~clk;

  heap_record_serializer dut (
    .clk(clk), .rst(rst), .dIn(dIn), .dInValid(dInValid),
    .wordOut(wordOut), .wordValid(wordValid), .wordReady(wordReady),
    .wordFirst(wordFirst), .wordLast(wordLast), .level(level),
    .overflow(overflow), .dropCount(dropCount)
  );

  heap_record_serializer #(.DEPTH(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .dIn(dIn), .dInValid(dInValid1),
    .wordOut(wordOut1), .wordValid(wordValid1), .wordReady(wordReady1),
    .wordFirst(wordFirst1), .wordLast(wordLast1), .level(level1),
    .overflow(overflow1), .dropCount(dropCount1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic heap_record_t mk(input logic [63:0] base);
    heap_record_t r;
    for (int k = 0; k < HEAP_BEATS; k++) r[k*64 +: 64] = base + 64'(k);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && wordValid && wordReady) begin
      xfer_cnt++;
      if (q.size() == 0) chk("extra_beat", wordOut, 64'hx);
      else begin
        mon_e = q.pop_front();
        chk("word", wordOut, mon_e.w);
        chk("first", 64'(wordFirst), 64'(mon_e.f));
        chk("last", 64'(wordLast), 64'(mon_e.l));
      end
    end
    if (prev_stall) begin
      chk("hold_valid", 64'(wordValid), 64'd1);
      chk("hold_word", wordOut, prev.w);
      chk("hold_first", 64'(wordFirst), 64'(prev.f));
      chk("hold_last", 64'(wordLast), 64'(prev.l));
    end
    prev_stall = !rst && wordValid && !wordReady;
    prev = '{wordOut, wordFirst, wordLast};
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] base, input bit acc);
    if (acc)
      for (int k = 0; k < HEAP_BEATS; k++) q.push_back('{base + 64'(k), k == 0, k == HEAP_BEATS - 1});
    @(posedge clk);
    #1 dIn = mk(base);
    dInValid = 1;
    @(posedge clk);
    #1 dInValid = 0;
  endtask

  task automatic drain(input logic [31:0] pat, input int start);
    for (int c = start; c < 200 && q.size() != 0; c++) begin
      @(posedge clk);
      #1 wordReady = pat[c%32];
      settle();
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1;
    wordReady = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{64'h00A0, 32'hFFFF_FFFF, 6};
    vecs[1] = '{64'h00A0, 32'h0000_0A69, 6};
    vecs[2] = '{64'h1000, 32'h5555_5555, 6};
    vecs[3] = '{64'hDEAD_0000, 32'h0000_0F0F, 6};
    el = '{1, 1, 2, 3, 4, 4};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wordOut", wordOut, 64'd0);
    chk("rst_wordValid", 64'(wordValid), 64'd0);
    chk("rst_wordFirst", 64'(wordFirst), 64'd0);
    chk("rst_wordLast", 64'(wordLast), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_dropCount", 64'(dropCount), 64'd0);
    rst = 0;

    for (int i = 0; i < 4; i++) begin
      xfer_cnt = 0;
      send(vecs[i].base, 1);
      settle();
      chk("lat_n1_valid", 64'(wordValid), 64'd0);
      @(posedge clk);
      #1 wordReady = vecs[i].pat[0];
      settle();
      chk("lat_n2_valid", 64'(wordValid), 64'd1);
      drain(vecs[i].pat, 1);
      @(posedge clk);
      #1;
      settle();
      chk("idle_after", 64'(wordValid), 64'd0);
      chk("xfer_count", 64'(xfer_cnt), 64'(vecs[i].exp_xfers));
    end

    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(64'h3000 + 64'(i * 16), i < 5);
      chk("fill_level", 64'(level), 64'(el[i]));
      chk("fill_overflow", 64'(overflow), 64'(i == 5));
      chk("fill_dropCount", 64'(dropCount), 64'(i == 5));
    end
    xfer_cnt = 0;
    drain(32'hFFFF_FFFF, 0);
    chk("fill_xfers", 64'(xfer_cnt), 64'd30);
    chk("fill_overflow_sticky", 64'(overflow), 64'd1);
    chk("fill_dropCount_hold", 64'(dropCount), 64'd1);

    do_reset();
    send(64'h4000, 1);
    send(64'h4100, 1);
    settle();
    chk("nb_level", 64'(level), 64'd1);
    @(posedge clk);
    #1 wordReady = 1;
    for (int c = 0; c < 12; c++) begin
      settle();
      chk("nb_valid", 64'(wordValid), 64'd1);
      @(posedge clk);
      #1;
    end
    settle();
    chk("nb_idle", 64'(wordValid), 64'd0);
    chk("nb_empty", 64'(q.size()), 64'd0);

    do_reset();
    send(64'h5000, 1);
    send(64'h5100, 1);
    send(64'h5200, 1);
    chk("mr_level", 64'(level), 64'd2);
    @(posedge clk);
    #1 wordReady = 1;
    repeat (3) @(posedge clk);
    #1 wordReady = 0;
    rst = 1;
    settle();
    chk("mr_beat3_word", wordOut, 64'h5003);
    chk("mr_beat3_first", 64'(wordFirst), 64'd0);
    @(posedge clk);
    #1 rst = 0;
    q.delete();
    settle();
    chk("mr_valid", 64'(wordValid), 64'd0);
    chk("mr_level0", 64'(level), 64'd0);
    chk("mr_overflow", 64'(overflow), 64'd0);
    send(64'h6000, 1);
    drain(32'hFFFF_FFFF, 0);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 dIn = mk(64'h7000 + 64'(i * 16));
      dInValid1 = 1;
      @(posedge clk);
      #1 dInValid1 = 0;
      if (i == 2) chk("sat_no_drop_yet", 64'(overflow1), 64'd0);
      if (i == 3) chk("sat_first_drop", 64'(dropCount1), 64'd1);
    end
    chk("sat_dropCount", 64'(dropCount1), 64'd3);
    chk("sat_overflow", 64'(overflow1), 64'd1);
    chk("sat_level", 64'(level1), 64'd2);
    do_reset();
    chk("sat_rst_overflow", 64'(overflow1), 64'd0);
    chk("sat_rst_dropCount", 64'(dropCount1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
